scmp_bus_target: RTL and testbench

- Bus responder for the SC/MP core's external bus.
- Decodes each ADS_n/RD_n/WR_n cycle issued by the CPU and latches the full 16-bit address: 12 address pins plus A15:12 multiplexed on the data bus during ADS_n, together with the status flags (H, D, I, R).
- Drives a synchronous single-port memory, returns read data on the CPU's D_i, and flags bus-protocol violations.
- Sits between the CPU core and RAM/ROM in the top-level system.

---
 rtl/scmp_bus_pak.sv | 24 ++
 rtl/scmp_bus_lat_ctr.sv | 64 ++++++
 rtl/scmp_bus_target.sv | 189 ++++++++++++++++++
 tb/tb_scmp_bus_target.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scmp_bus_pak.sv
// Shared types and constants for the SC/MP external-bus responder.
package scmp_bus_pak;

  // Bus-cycle phases seen from the target side.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } BUS_ST_t;

  // Bit positions of the status flags inside the 4-bit {H,D,I,R} nibble.
  localparam int unsigned FLG_IX_R = 0;
  localparam int unsigned FLG_IX_I = 1;
  localparam int unsigned FLG_IX_D = 2;
  localparam int unsigned FLG_IX_H = 3;

  // Value the CPU sees when nobody drives the data bus.
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // Width of the read-latency down-counter (latency range 1..4).
  localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/scmp_bus_lat_ctr.sv
// Read-latency down-counter: counts RD_LAT clocks after a load, then raises
// capture for one clock and holds ready until cleared.
module scmp_bus_lat_ctr
  import scmp_bus_pak::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,      // abandon / finish the access
  input  logic load,     // start counting RD_LAT clocks
  input  logic set_rdy,  // ready at once, no memory involved
  output logic capture,  // read data is valid on the memory port this clock
  output logic ready
);

  logic [LAT_W-1:0] lat_cnt, lat_cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  // Counter and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      lat_cnt <= lat_cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: clear wins over load, load over immediate-ready.
  always_comb begin
    lat_cnt_d = lat_cnt;
    busy_d    = busy_q;
    ready_d   = ready_q;
    if (clr) begin
      lat_cnt_d = '0;
      busy_d    = 1'b0;
      ready_d   = 1'b0;
    end else if (load) begin
      lat_cnt_d = LAT_W'(RD_LAT);
      busy_d    = 1'b1;
      ready_d   = 1'b0;
    end else if (set_rdy) begin
      lat_cnt_d = '0;
      busy_d    = 1'b0;
      ready_d   = 1'b1;
    end else if (busy_q) begin
      if (lat_cnt == '0) begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end else begin
        lat_cnt_d = lat_cnt - LAT_W'(1);
      end
    end
  end

  assign capture = busy_q && (lat_cnt == '0);
  assign ready   = ready_q;

endmodule

// File: rtl/scmp_bus_target.sv
// SC/MP external-bus target: decodes ADS_n/RD_n/WR_n cycles, drives a
// synchronous single-port memory and reports bus-protocol errors.
module scmp_bus_target
  import scmp_bus_pak::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_D_o,
  input  logic        cpu_ADS_n,
  input  logic        cpu_RD_n,
  input  logic        cpu_WR_n,
  output logic [7:0]  cpu_D_i,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [3:0]  cyc_flags,
  output logic [15:0] fetch_cnt,
  output logic        err_both,
  output logic        err_no_ads
);

  BUS_ST_t     state_q, state_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        err_both_q, err_both_d;
  logic        err_no_ads_q, err_no_ads_d;
  logic        strb_prev_q;

  logic        lat_clr, lat_load, lat_set_rdy, lat_capture, lat_ready;
  logic        strb_now, strb_both, mapped;
  logic [15:0] ads_addr;
  logic [3:0]  ads_flags;

  assign strb_now  = !cpu_RD_n || !cpu_WR_n;
  assign strb_both = !cpu_RD_n && !cpu_WR_n;
  assign mapped    = 32'(mem_addr_q) < MEM_SIZE;
  // During ADS_n the data bus carries {H,D,I,R,A15:12}.
  assign ads_addr  = {cpu_D_o[3:0], cpu_addr};
  assign ads_flags = cpu_D_o[7:4];

  scmp_bus_lat_ctr #(
    .RD_LAT(RD_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .clr    (lat_clr),
    .load   (lat_load),
    .set_rdy(lat_set_rdy),
    .capture(lat_capture),
    .ready  (lat_ready)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      flags_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      fetch_cnt_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      err_both_q   <= 1'b0;
      err_no_ads_q <= 1'b0;
      strb_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      flags_q      <= flags_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      fetch_cnt_q  <= fetch_cnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      err_both_q   <= err_both_d;
      err_no_ads_q <= err_no_ads_d;
      strb_prev_q  <= strb_now;
    end
  end

  // Bus-cycle decode: next state, memory strobes and error pulses.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    flags_d      = flags_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    fetch_cnt_d  = fetch_cnt_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    err_both_d   = 1'b0;
    err_no_ads_d = 1'b0;
    lat_load     = 1'b0;
    lat_set_rdy  = 1'b0;

    if (state_q == READ && lat_capture) rdata_d = mem_rdata;

    unique case (state_q)
      IDLE: begin
        if (!cpu_ADS_n) begin
          mem_addr_d = ads_addr;
          flags_d    = ads_flags;
          state_d    = ADDR;
        end else if (strb_now && !strb_prev_q) begin
          // Only the falling strobe reports; a held strobe stays quiet.
          err_no_ads_d = 1'b1;
        end
      end
      ADDR: begin
        if (!cpu_ADS_n) begin
          mem_addr_d = ads_addr;
          flags_d    = ads_flags;
        end else if (strb_both) begin
          err_both_d = 1'b1;
          state_d    = IDLE;
        end else if (!cpu_RD_n) begin
          state_d = READ;
          if (mapped) begin
            mem_rd_d = 1'b1;
            lat_load = 1'b1;
          end else begin
            lat_set_rdy = 1'b1;
            rdata_d     = OPEN_BUS;
          end
        end else if (!cpu_WR_n) begin
          state_d = WRITE;
          wdata_d = cpu_D_o;
        end
      end
      READ: begin
        if (!cpu_ADS_n) begin
          mem_addr_d = ads_addr;
          flags_d    = ads_flags;
          state_d    = ADDR;
        end else if (strb_both) begin
          err_both_d = 1'b1;
          state_d    = IDLE;
        end else if (cpu_RD_n) begin
          state_d = IDLE;
          if (lat_ready && flags_q[FLG_IX_I] && fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
          end
        end
      end
      WRITE: begin
        if (!cpu_ADS_n) begin
          mem_addr_d = ads_addr;
          flags_d    = ads_flags;
          state_d    = ADDR;
        end else if (strb_both) begin
          err_both_d = 1'b1;
          state_d    = IDLE;
        end else if (!cpu_WR_n) begin
          wdata_d = cpu_D_o;
        end else begin
          mem_wr_d = mapped;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any exit from READ drops the pending access so late data is ignored.
  assign lat_clr = (state_d != READ);

  assign cpu_D_i    = (state_q == READ && lat_ready) ? rdata_q : OPEN_BUS;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = wdata_q;
  assign cyc_flags  = flags_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign err_both   = err_both_q;
  assign err_no_ads = err_no_ads_q;

endmodule

// File: tb/tb_scmp_bus_target.sv
// Bench for scmp_bus_target: two instances share the CPU bus, one with
// RD_LAT=1/32 KiB decode, one with RD_LAT=3/4 KiB decode.
module tb_scmp_bus_target;
  import scmp_bus_pak::*;

  localparam int unsigned MEM_A = 32768;
  localparam int unsigned MEM_B = 4096;
  localparam int NEED_A = 3;  // RD_LAT=1: data visible after 1+2 edges
  localparam int NEED_B = 5;  // RD_LAT=3

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_D_o = '0;
  logic ads_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;

  logic [7:0]  d_i_a, wdata_a, d_i_b, wdata_b;
  logic [7:0]  rdata_a = '0, rdata_b = '0, pb0 = '0, pb1 = '0;
  logic [15:0] mem_addr_a, fetch_a, mem_addr_b, fetch_b;
  logic        mem_rd_a, mem_wr_a, eb_a, ena_a, mem_rd_b, mem_wr_b, eb_b, ena_b;
  logic [3:0]  flags_a, flags_b;

  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:4095];

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0]  shadow_a [int];
  logic [7:0]  shadow_b [int];
  logic [7:0]  rdq_a [$];
  logic [7:0]  rdq_b [$];
  logic [23:0] wrq_a [$];
  logic [15:0] fetch_exp_a = '0, fetch_exp_b = '0;

  always #5 clk = ~clk;

  scmp_bus_target #(.RD_LAT(1), .MEM_SIZE(MEM_A)) dut_a (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_D_o(cpu_D_o), .cpu_ADS_n(ads_n),
    .cpu_RD_n(rd_n), .cpu_WR_n(wr_n), .cpu_D_i(d_i_a), .mem_addr(mem_addr_a),
    .mem_rd(mem_rd_a), .mem_wr(mem_wr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
    .cyc_flags(flags_a), .fetch_cnt(fetch_a), .err_both(eb_a), .err_no_ads(ena_a)
  );

  scmp_bus_target #(.RD_LAT(3), .MEM_SIZE(MEM_B)) dut_b (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_D_o(cpu_D_o), .cpu_ADS_n(ads_n),
    .cpu_RD_n(rd_n), .cpu_WR_n(wr_n), .cpu_D_i(d_i_b), .mem_addr(mem_addr_b),
    .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .cyc_flags(flags_b), .fetch_cnt(fetch_b), .err_both(eb_b), .err_no_ads(ena_b)
  );

  // Memory models: one-clock and three-clock synchronous reads.
  always @(posedge clk) begin
    if (mem_wr_a) mem_a[mem_addr_a] <= wdata_a;
    if (mem_rd_a) rdata_a <= mem_a[mem_addr_a];
  end

  always @(posedge clk) begin
    if (mem_wr_b) mem_b[mem_addr_b[11:0]] <= wdata_b;
    if (mem_rd_b) pb0 <= mem_b[mem_addr_b[11:0]];
    pb1     <= pb0;
    rdata_b <= pb1;
  end

  // Address phase: drive ADS_n for one clock, return at the next falling edge.
  task automatic bus_ads(input logic [15:0] a16, input logic [3:0] flg);
    cpu_addr = a16[11:0];
    cpu_D_o  = {flg, a16[15:12]};
    ads_n    = 1'b0;
    @(negedge clk);
    ads_n = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] a16, input logic [3:0] flg, input int hold);
    logic ma, mb;
    logic [7:0] ea, eb_v, xa, xb;
    int need_a, need_b;
    ma = int'(a16) < MEM_A;
    mb = int'(a16) < MEM_B;
    need_a = ma ? NEED_A : 1;
    need_b = mb ? NEED_B : 1;
    ea = 8'h00;
    eb_v = 8'h00;
    if (ma && hold >= need_a) rdq_a.push_back(shadow_a.exists(int'(a16)) ? shadow_a[int'(a16)] : 8'h00);
    if (mb && hold >= need_b) rdq_b.push_back(shadow_b.exists(int'(a16)) ? shadow_b[int'(a16)] : 8'h00);
    bus_ads(a16, flg);
    n_checks++;
    if (mem_addr_a !== a16 || flags_a !== flg)
      $display("FAIL rd_addr: got %h/%h want %h/%h", mem_addr_a, flags_a, a16, flg);
    else n_pass++;
    rd_n = 1'b0;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_rd_a !== (k == 1 && ma) || mem_rd_b !== (k == 1 && mb))
        $display("FAIL rd_strobe k=%0d: got %b/%b want %b/%b", k, mem_rd_a, mem_rd_b,
                 (k == 1 && ma), (k == 1 && mb));
      else n_pass++;
      xa = OPEN_BUS;
      if (ma && k >= need_a) begin
        if (k == need_a) ea = rdq_a.pop_front();
        xa = ea;
      end
      xb = OPEN_BUS;
      if (mb && k >= need_b) begin
        if (k == need_b) eb_v = rdq_b.pop_front();
        xb = eb_v;
      end
      n_checks++;
      if (d_i_a !== xa || d_i_b !== xb)
        $display("FAIL rd_data %h k=%0d: got %h/%h want %h/%h", a16, k, d_i_a, d_i_b, xa, xb);
      else n_pass++;
    end
    rd_n = 1'b1;
    if (hold >= need_a && flg[FLG_IX_I] && fetch_exp_a != 16'hFFFF) fetch_exp_a++;
    if (hold >= need_b && flg[FLG_IX_I] && fetch_exp_b != 16'hFFFF) fetch_exp_b++;
    @(negedge clk);
    n_checks++;
    if (fetch_a !== fetch_exp_a || fetch_b !== fetch_exp_b || d_i_a !== OPEN_BUS)
      $display("FAIL rd_end %h: got cnt %h/%h d %h want cnt %h/%h d ff", a16, fetch_a,
               fetch_b, d_i_a, fetch_exp_a, fetch_exp_b);
    else n_pass++;
  endtask

  task automatic do_write(input logic [15:0] a16, input logic [7:0] d0, input logic [7:0] d1,
                          input int n);
    logic ma, mb;
    logic [7:0] last;
    logic [23:0] exp;
    ma = int'(a16) < MEM_A;
    mb = int'(a16) < MEM_B;
    last = (n > 1) ? d1 : d0;
    bus_ads(a16, 4'h0);
    wr_n = 1'b0;
    cpu_D_o = d0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_wr_a !== 1'b0 || mem_wr_b !== 1'b0)
        $display("FAIL wr_early: got %b/%b want 0/0", mem_wr_a, mem_wr_b);
      else n_pass++;
      if (k < n) cpu_D_o = d1;
    end
    wr_n = 1'b1;
    if (ma) begin
      wrq_a.push_back({a16, last});
      shadow_a[int'(a16)] = last;
    end
    if (mb) shadow_b[int'(a16)] = last;
    @(negedge clk);
    n_checks++;
    if (mem_wr_a !== ma || mem_wr_b !== mb || mem_rd_a !== 1'b0)
      $display("FAIL wr_strobe %h: got %b/%b want %b/%b", a16, mem_wr_a, mem_wr_b, ma, mb);
    else n_pass++;
    if (mem_wr_a === 1'b1 && wrq_a.size() > 0) begin
      exp = wrq_a.pop_front();
      n_checks++;
      if ({mem_addr_a, wdata_a} !== exp)
        $display("FAIL wr_data: got %h want %h", {mem_addr_a, wdata_a}, exp);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (mem_wr_a !== 1'b0 || mem_wr_b !== 1'b0)
      $display("FAIL wr_pulse: got %b/%b want 0/0", mem_wr_a, mem_wr_b);
    else n_pass++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (d_i_a !== 8'hFF || mem_addr_a !== 16'h0 || mem_rd_a !== 1'b0 || mem_wr_a !== 1'b0 ||
        wdata_a !== 8'h0 || flags_a !== 4'h0 || fetch_a !== 16'h0 || eb_a !== 1'b0 ||
        ena_a !== 1'b0 || dut_a.state_q !== IDLE)
      $display("FAIL reset: got d=%h a=%h rd=%b wr=%b wd=%h f=%h c=%h eb=%b ena=%b", d_i_a,
               mem_addr_a, mem_rd_a, mem_wr_a, wdata_a, flags_a, fetch_a, eb_a, ena_a);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_basic;
    do_write(16'h5123, 8'hA5, 8'hA5, 1);
    do_read(16'h5123, 4'h2, NEED_A);  // I=1: counted
    do_read(16'h5123, 4'h4, NEED_A);  // D only: not counted
  endtask

  task automatic test_write;
    do_write(16'h0010, 8'h11, 8'h22, 2);
    do_read(16'h0010, 4'h2, NEED_B);
  endtask

  task automatic test_unmapped;
    do_write(16'h1000, 8'h77, 8'h77, 1);
    do_read(16'h1000, 4'h2, NEED_A);
    do_write(16'h0FFF, 8'h5A, 8'h5A, 1);
    do_read(16'h0FFF, 4'h2, NEED_B);
  endtask

  task automatic test_errors;
    bus_ads(16'h0010, 4'h2);
    rd_n = 1'b0;
    wr_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (eb_a !== 1'b1 || eb_b !== 1'b1 || mem_rd_a !== 1'b0 || mem_wr_a !== 1'b0 ||
        ena_a !== 1'b0 || dut_a.state_q !== IDLE)
      $display("FAIL err_both: got eb=%b/%b rd=%b wr=%b ena=%b", eb_a, eb_b, mem_rd_a, mem_wr_a,
               ena_a);
    else n_pass++;
    rd_n = 1'b1;
    wr_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (eb_a !== 1'b0 || ena_a !== 1'b0)
      $display("FAIL err_both_pulse: got eb=%b ena=%b want 0 0", eb_a, ena_a);
    else n_pass++;
    rd_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ena_a !== 1'b1 || ena_b !== 1'b1 || mem_rd_a !== 1'b0)
      $display("FAIL err_no_ads: got %b/%b rd=%b want 1/1 0", ena_a, ena_b, mem_rd_a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ena_a !== 1'b0 || mem_rd_a !== 1'b0)
      $display("FAIL err_no_ads_pulse: got %b rd=%b want 0 0", ena_a, mem_rd_a);
    else n_pass++;
    rd_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut_a.state_q !== IDLE || d_i_a !== 8'hFF)
      $display("FAIL no_ads_idle: got st=%0d d=%h want 0 ff", dut_a.state_q, d_i_a);
    else n_pass++;
  endtask

  task automatic test_abandon;
    do_read(16'h0010, 4'h2, 2);  // released before either instance is ready
    do_write(16'h0020, 8'hC3, 8'hC3, 1);
    do_read(16'h0020, 4'h2, NEED_B);  // stale 8'h22 must not appear
  endtask

  task automatic test_reset_mid;
    bus_ads(16'h0010, 4'h2);
    rd_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (d_i_b !== 8'hFF || mem_addr_b !== 16'h0 || flags_b !== 4'h0 || fetch_b !== 16'h0 ||
        fetch_a !== 16'h0 || mem_rd_b !== 1'b0 || dut_b.state_q !== IDLE)
      $display("FAIL reset_mid: got d=%h a=%h f=%h c=%h/%h rd=%b", d_i_b, mem_addr_b, flags_b,
               fetch_a, fetch_b, mem_rd_b);
    else n_pass++;
    rd_n = 1'b1;
    fetch_exp_a = '0;
    fetch_exp_b = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_rd_b !== 1'b0 || mem_wr_b !== 1'b0 || d_i_b !== 8'hFF)
        $display("FAIL post_reset k=%0d: got rd=%b wr=%b d=%h", k, mem_rd_b, mem_wr_b, d_i_b);
      else n_pass++;
    end
    do_read(16'h0020, 4'h2, NEED_B);
  endtask

  task automatic test_back_to_back;
    bus_ads(16'h0010, 4'h2);
    rd_n = 1'b0;
    @(negedge clk);
    cpu_addr = 12'h020;
    cpu_D_o = 8'h20;
    ads_n = 1'b0;
    rd_n = 1'b1;
    @(negedge clk);
    ads_n = 1'b1;
    n_checks++;
    if (dut_a.state_q !== ADDR || mem_addr_a !== 16'h0020 || fetch_a !== fetch_exp_a)
      $display("FAIL ads_in_read: got st=%0d a=%h c=%h want 1 0020 %h", dut_a.state_q,
               mem_addr_a, fetch_a, fetch_exp_a);
    else n_pass++;
    rd_n = 1'b0;
    repeat (NEED_A) @(negedge clk);
    n_checks++;
    if (d_i_a !== 8'hC3) $display("FAIL b2b_data: got %h want c3", d_i_a);
    else n_pass++;
    rd_n = 1'b1;
    fetch_exp_a++;
    @(negedge clk);
    n_checks++;
    if (fetch_a !== fetch_exp_a || fetch_b !== fetch_exp_b)
      $display("FAIL b2b_cnt: got %h/%h want %h/%h", fetch_a, fetch_b, fetch_exp_a, fetch_exp_b);
    else n_pass++;
  endtask

  task automatic test_saturate;
    // Preload the counter near its limit instead of issuing 65k reads.
    force dut_a.fetch_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut_a.fetch_cnt_q;
    fetch_exp_a = 16'hFFFE;
    @(negedge clk);
    n_checks++;
    if (fetch_a !== 16'hFFFE) $display("FAIL sat_preload: got %h want fffe", fetch_a);
    else n_pass++;
    do_read(16'h0020, 4'h2, NEED_A);
    do_read(16'h0020, 4'h2, NEED_A);
    n_checks++;
    if (fetch_a !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", fetch_a);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write();
    test_unmapped();
    test_errors();
    test_abandon();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
